// File: rtl/nird_riu2_coder.sv
// nird_riu2_coder: two-stage riu2 coder for NI/RD sign patterns with frame sequencing and backpressure
module nird_riu2_coder #(
  parameter int P = 8,
  parameter int FRAME_PIX = 676,
  localparam int CW = $clog2(P + 2),
  localparam int JW = $clog2((P + 2) * (P + 2)),
  localparam int NW = $clog2(FRAME_PIX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_i,
  input  logic          done_i,
  input  logic [P-1:0]  ni_bits_i,
  input  logic [P-1:0]  rd_bits_i,
  output logic          ready_o,
  input  logic          ready_i,
  output logic [CW-1:0] ni_o,
  output logic [CW-1:0] rd_o,
  output logic [JW-1:0] joint_o,
  output logic          done_o,
  output logic          progress_done_o,
  output logic          err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [NW-1:0] in_cnt, out_cnt;
  logic mode_q, v1, en, acc, xfer;
  logic [P-1:0] ni_q, rd_q;
  logic [CW-1:0] ni_c, rd_c;
  logic [JW-1:0] joint_c;
  // uniform patterns have at most two circular transitions; all others share code P+1
  function automatic logic [CW-1:0] riu2(input logic [P-1:0] b);
    logic [P-1:0] t;
    logic [CW-1:0] u, c;
    t = b ^ {b[0], b[P-1:1]};
    u = '0;
    c = '0;
    for (int i = 0; i < P; i++) begin
      u += CW'(t[i]);
      c += CW'(b[i]);
    end
    return (u <= CW'(2)) ? c : CW'(P + 1);
  endfunction
  assign en = ~done_o | ready_i;
  assign ready_o = en & (state != DRAIN) & ~rst;
  assign acc = done_i & ready_o;
  assign xfer = done_o & ready_i;
  assign ni_c = riu2(ni_q);
  assign rd_c = riu2(rd_q);
  assign joint_c = mode_q ? JW'(ni_c) * JW'(P + 2) + JW'(rd_c) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      mode_q <= 1'b0;
      v1 <= 1'b0;
      ni_q <= '0;
      rd_q <= '0;
      ni_o <= '0;
      rd_o <= '0;
      joint_o <= '0;
      done_o <= 1'b0;
      progress_done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      progress_done_o <= 1'b0;
      if (en) begin
        v1 <= acc;
        if (acc) begin
          ni_q <= ni_bits_i;
          rd_q <= rd_bits_i;
        end
        done_o <= v1;
        ni_o <= ni_c;
        rd_o <= rd_c;
        joint_o <= joint_c;
      end
      if (done_i && !ready_o) err_o <= 1'b1;
      if (xfer) out_cnt <= out_cnt + NW'(1);
      case (state)
        IDLE: if (acc) begin
          mode_q <= mode_i;
          err_o <= 1'b0;
          in_cnt <= NW'(1);
          state <= (FRAME_PIX == 1) ? DRAIN : RUN;
        end
        RUN: if (acc) begin
          in_cnt <= in_cnt + NW'(1);
          if (in_cnt + NW'(1) == NW'(FRAME_PIX)) state <= DRAIN;
        end
        DRAIN: if (xfer && out_cnt + NW'(1) == NW'(FRAME_PIX)) begin
          state <= IDLE;
          in_cnt <= '0;
          out_cnt <= '0;
          progress_done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nird_riu2_coder.sv
// tb_nird_riu2_coder: directed stimulus against a queue-based frame model of the riu2 coder
module tb_nird_riu2_coder;
  localparam int FP = 4;
  logic clk = 0, rst, mode_i, done_i, ready_i, ready_o, done_o, progress_done_o, err_o;
  logic [7:0] ni_bits_i, rd_bits_i;
  logic [3:0] ni_o, rd_o;
  logic [6:0] joint_o;
  int n_cmp = 0, n_err = 0;

  nird_riu2_coder #(.P(8), .FRAME_PIX(FP)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .done_i(done_i),
    .ni_bits_i(ni_bits_i), .rd_bits_i(rd_bits_i), .ready_o(ready_o),
    .ready_i(ready_i), .ni_o(ni_o), .rd_o(rd_o), .joint_o(joint_o),
    .done_o(done_o), .progress_done_o(progress_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // count circular transitions and ones directly from the definition
  function automatic int riu(input logic [7:0] b);
    int u, c;
    u = 0;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] != b[(i + 1) % 8]) u++;
      if (b[i]) c++;
    end
    return (u <= 2) ? c : 9;
  endfunction

  int qn[$], qr[$], qj[$];
  int m_acc, m_xfer, h_ni, h_rd, h_j;
  bit started = 0, m_drain, m_mode, m_err, exp_zero, exp_prog, hold, exp_ready;

  always @(negedge clk) begin
    if (rst && !started) begin
      started = 1;
      qn.delete(); qr.delete(); qj.delete();
      m_acc = 0; m_xfer = 0; m_drain = 0; m_err = 0; exp_zero = 1; exp_prog = 0; hold = 0;
    end else if (started) begin
      exp_ready = !rst && !(done_o && !ready_i) && !m_drain;
      if (exp_zero) begin
        chk("rst_done", done_o, 0);
        chk("rst_prog", progress_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ni", ni_o, 0);
        chk("rst_joint", joint_o, 0);
      end else begin
        if (done_o) begin
          if (qn.size() == 0) chk("dup_out", qn.size(), 1);
          else begin
            chk("m_ni", ni_o, qn[0]);
            chk("m_rd", rd_o, qr[0]);
            chk("m_joint", joint_o, qj[0]);
          end
        end
        if (hold) begin
          chk("hold_done", done_o, 1);
          chk("hold_ni", ni_o, h_ni);
          chk("hold_rd", rd_o, h_rd);
          chk("hold_joint", joint_o, h_j);
        end
        chk("m_prog", progress_done_o, exp_prog);
        chk("m_err", err_o, m_err);
      end
      chk("m_ready", ready_o, exp_ready);
      if (rst) begin
        qn.delete(); qr.delete(); qj.delete();
        m_acc = 0; m_xfer = 0; m_drain = 0; m_err = 0; exp_zero = 1; exp_prog = 0; hold = 0;
      end else begin
        exp_zero = 0;
        exp_prog = 0;
        if (done_i && !exp_ready) m_err = 1;
        if (done_i && exp_ready) begin
          if (m_acc == 0) begin
            m_mode = mode_i;
            m_err = 0;
          end
          qn.push_back(riu(ni_bits_i));
          qr.push_back(riu(rd_bits_i));
          qj.push_back(m_mode ? riu(ni_bits_i) * 10 + riu(rd_bits_i) : 0);
          m_acc++;
          if (m_acc == FP) m_drain = 1;
        end
        if (done_o && ready_i && qn.size() > 0) begin
          void'(qn.pop_front()); void'(qr.pop_front()); void'(qj.pop_front());
          m_xfer++;
          if (m_xfer == FP) begin
            exp_prog = 1;
            m_acc = 0; m_xfer = 0; m_drain = 0;
          end
        end
        hold = done_o && !ready_i;
        h_ni = ni_o; h_rd = rd_o; h_j = joint_o;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_prog;
    int got;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      tick;
      if (progress_done_o) got = 1;
    end
    chk("prog_seen", got, 1);
  endtask

  logic [7:0] tn [4] = '{8'h00, 8'hC3, 8'h7F, 8'h24};
  logic [7:0] tr [4] = '{8'hFE, 8'h99, 8'h18, 8'hFF};

  initial begin
    rst = 1; done_i = 0; mode_i = 0; ni_bits_i = 0; rd_bits_i = 0; ready_i = 1;
    repeat (3) tick;
    rst = 0;
    #1 chk("ready_after_rst", ready_o, 1);
    chk("rst_err0", err_o, 0);
    mode_i = 1; done_i = 1; ni_bits_i = 8'h00; rd_bits_i = 8'hFF;
    tick;
    chk("lat_not_yet", done_o, 0);
    ni_bits_i = 8'h0F; rd_bits_i = 8'h55;
    tick;
    chk("v1_done", done_o, 1); chk("v1_ni", ni_o, 0); chk("v1_rd", rd_o, 8); chk("v1_joint", joint_o, 8);
    ni_bits_i = 8'h01; rd_bits_i = 8'h05;
    tick;
    chk("v2_ni", ni_o, 4); chk("v2_rd", rd_o, 9); chk("v2_joint", joint_o, 49);
    ni_bits_i = 8'h00; rd_bits_i = 8'h00;
    tick;
    chk("v3_ni", ni_o, 1); chk("v3_rd", rd_o, 9); chk("v3_joint", joint_o, 19);
    done_i = 0;
    #1 chk("drain_ready", ready_o, 0);
    tick;
    chk("v4_done", done_o, 1); chk("v4_joint", joint_o, 0); chk("v4_prog", progress_done_o, 0);
    tick;
    chk("end_prog", progress_done_o, 1); chk("end_done", done_o, 0); chk("end_ready", ready_o, 1);
    tick;
    chk("prog_once", progress_done_o, 0);
    mode_i = 0; done_i = 1; ni_bits_i = 8'h03; rd_bits_i = 8'hF0;
    tick;
    mode_i = 1; ni_bits_i = 8'h81; rd_bits_i = 8'h5A;
    tick;
    ready_i = 0; done_i = 0;
    repeat (5) begin
      tick;
      chk("stall_done", done_o, 1); chk("stall_ni", ni_o, 2);
      chk("stall_joint", joint_o, 0); chk("stall_ready", ready_o, 0);
    end
    ready_i = 1; done_i = 1; ni_bits_i = 8'hFF; rd_bits_i = 8'h00;
    tick;
    ni_bits_i = 8'h10; rd_bits_i = 8'h11;
    tick;
    ni_bits_i = 8'hAA;
    tick;
    done_i = 0;
    chk("drop_err", err_o, 1);
    wait_prog;
    chk("err_at_end", err_o, 1);
    mode_i = 1; done_i = 1; ni_bits_i = 8'h07; rd_bits_i = 8'h0F;
    tick;
    chk("err_cleared", err_o, 0);
    ni_bits_i = 8'h3C; rd_bits_i = 8'h01;
    tick;
    done_i = 0;
    chk("m1_done", done_o, 1); chk("m1_joint", joint_o, 34);
    rst = 1;
    tick;
    rst = 0;
    chk("abort_done", done_o, 0); chk("abort_ni", ni_o, 0); chk("abort_joint", joint_o, 0);
    chk("abort_prog", progress_done_o, 0);
    #1 chk("abort_ready", ready_o, 1);
    for (int k = 0; k < 4; k++) begin
      done_i = 1; ni_bits_i = tn[k]; rd_bits_i = tr[k];
      tick;
    end
    done_i = 0;
    wait_prog;
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
